imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 63 ++++++
 tb/tb_imem_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams program bytes into instruction memory, then releases the CPU and latches its stop status
module imem_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [7:0]    imem_wdata,
    input  logic [1:0]    cpu_status,
    output logic          cpu_run,
    output logic [AW:0]   byte_count,
    output logic [1:0]    state,
    output logic [1:0]    final_status,
    output logic          load_err
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, STOP = 2'd3;
    localparam logic [AW:0] FULL = (AW+1)'(MEM_BYTES);
    logic xfer, full;
    always_comb begin
        in_ready   = rst_n && state == LOAD;
        xfer       = in_valid && in_ready;
        full       = byte_count == FULL;
        imem_we    = xfer && !full;
        imem_addr  = byte_count[AW-1:0];
        imem_wdata = in_data;
    end
    // a byte arriving with memory already full is dropped and aborts the load with ADR
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cpu_run      <= 1'b0;
            byte_count   <= '0;
            final_status <= 2'd0;
            load_err     <= 1'b0;
        end else if ((state == IDLE || state == STOP) && load_start) begin
            state        <= LOAD;
            byte_count   <= '0;
            final_status <= 2'd0;
            load_err     <= 1'b0;
        end else if (xfer && full) begin
            state        <= STOP;
            final_status <= 2'd3;
            load_err     <= 1'b1;
        end else if (imem_we) begin
            byte_count <= byte_count + 1'b1;
            if (in_last) begin
                state   <= RUN;
                cpu_run <= 1'b1;
            end
        end else if (state == RUN && cpu_status != 2'd0) begin
            state        <= STOP;
            final_status <= cpu_status;
            cpu_run      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: vector table, directed corner sequences and randomized cycles checked against a queue-based model
module tb_imem_loader;
    localparam int MEM = 16, AW = 4;
    logic clk = 1'b0, rst_n = 1'b0, load_start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [1:0] cpu_status = 2'd0;
    logic in_ready, imem_we, cpu_run, load_err;
    logic [AW-1:0] imem_addr;
    logic [7:0] imem_wdata;
    logic [AW:0] byte_count;
    logic [1:0] state, final_status;

    imem_loader #(.MEM_BYTES(MEM), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_status(cpu_status),
        .cpu_run(cpu_run), .byte_count(byte_count), .state(state),
        .final_status(final_status), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rn, ls, iv;
        logic [7:0] d;
        logic lst;
        logic [1:0] cs;
        logic we;
        logic [AW-1:0] addr;
        logic [1:0] st;
        logic [AW:0] cnt;
        logic run;
        logic [1:0] fs;
    } vec_t;

    int total = 0, bad = 0;
    int m_st = 0;
    logic [1:0] m_fs = 2'd0;
    logic m_err = 1'b0;
    byte unsigned img[$];
    int waddr[$];
    logic [7:0] mm [MEM];
    logic [7:0] shadow [MEM];
    logic c_we;
    logic [AW-1:0] c_addr;
    logic [7:0] prog [10];
    vec_t tbl [11];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
        end
    endtask

    // one clock: check combinational outputs, advance the model on the edge, check registered outputs
    task automatic cyc();
        logic rdy, we;
        #1;
        rdy = rst_n && m_st == 1;
        we = rdy && in_valid && img.size() < MEM;
        c_we = imem_we;
        c_addr = imem_addr;
        if (imem_we === 1'b1) begin
            shadow[imem_addr] = imem_wdata;
            waddr.push_back(int'(imem_addr));
        end
        chk("in_ready", in_ready, rdy);
        chk("imem_we", imem_we, we);
        if (we) begin
            chk("imem_addr", imem_addr, img.size());
            chk("imem_wdata", imem_wdata, in_data);
        end
        @(posedge clk);
        if (!rst_n) begin
            m_st = 0; img.delete(); m_fs = 2'd0; m_err = 1'b0;
        end else if ((m_st == 0 || m_st == 3) && load_start) begin
            m_st = 1; img.delete(); m_fs = 2'd0; m_err = 1'b0;
        end else if (m_st == 1 && in_valid) begin
            if (img.size() == MEM) begin
                m_st = 3; m_fs = 2'd3; m_err = 1'b1;
            end else begin
                mm[img.size()] = in_data;
                img.push_back(in_data);
                if (in_last) m_st = 2;
            end
        end else if (m_st == 2 && cpu_status != 2'd0) begin
            m_st = 3; m_fs = cpu_status;
        end
        #1;
        chk("state", state, m_st);
        chk("byte_count", byte_count, img.size());
        chk("cpu_run", cpu_run, m_st == 2);
        chk("final_status", final_status, m_fs);
        chk("load_err", load_err, m_err);
    endtask

    task automatic set(input logic rn, input logic ls, input logic iv, input logic [7:0] d,
                       input logic lst, input logic [1:0] cs);
        rst_n = rn; load_start = ls; in_valid = iv; in_data = d; in_last = lst; cpu_status = cs;
    endtask

    task automatic send(input logic [7:0] d, input logic lst);
        set(1'b1, 1'b0, 1'b1, d, lst, 2'd0);
        cyc();
    endtask

    task automatic start();
        set(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
        cyc();
        set(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
        cyc();
        waddr.delete();
        for (int i = 0; i < MEM; i++) shadow[i] = 8'hEE;
    endtask

    initial begin
        for (int i = 0; i < MEM; i++) begin mm[i] = 8'h00; shadow[i] = 8'h00; end
        prog = '{8'h30, 8'h00, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl = '{
            '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 4'd0, 2'd0, 5'd0, 1'b0, 2'd0},
            '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 4'd0, 2'd1, 5'd0, 1'b0, 2'd0},
            '{1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd0, 1'b1, 4'd0, 2'd1, 5'd1, 1'b0, 2'd0},
            '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 4'd0, 2'd1, 5'd1, 1'b0, 2'd0},
            '{1'b1, 1'b1, 1'b1, 8'hB2, 1'b0, 2'd0, 1'b1, 4'd1, 2'd1, 5'd2, 1'b0, 2'd0},
            '{1'b1, 1'b0, 1'b1, 8'hC3, 1'b1, 2'd3, 1'b1, 4'd2, 2'd2, 5'd3, 1'b1, 2'd0},
            '{1'b1, 1'b1, 1'b1, 8'hD4, 1'b0, 2'd0, 1'b0, 4'd0, 2'd2, 5'd3, 1'b1, 2'd0},
            '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0, 4'd0, 2'd3, 5'd3, 1'b0, 2'd2},
            '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 4'd0, 2'd3, 5'd3, 1'b0, 2'd2},
            '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 4'd0, 2'd1, 5'd0, 1'b0, 2'd0},
            '{1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 2'd0, 1'b0, 4'd0, 2'd0, 5'd0, 1'b0, 2'd0}
        };
        for (int i = 0; i < 11; i++) begin
            set(tbl[i].rn, tbl[i].ls, tbl[i].iv, tbl[i].d, tbl[i].lst, tbl[i].cs);
            cyc();
            chk("tbl_we", c_we, tbl[i].we);
            if (tbl[i].we) chk("tbl_addr", c_addr, tbl[i].addr);
            chk("tbl_state", state, tbl[i].st);
            chk("tbl_count", byte_count, tbl[i].cnt);
            chk("tbl_run", cpu_run, tbl[i].run);
            chk("tbl_fstat", final_status, tbl[i].fs);
        end

        start();
        for (int i = 0; i < 10; i++) send(prog[i], i == 9);
        chk("r37_count", byte_count, 10);
        chk("r37_state", state, 2);
        chk("r37_run", cpu_run, 1);
        chk("r37_nwrites", waddr.size(), 10);
        for (int i = 0; i < 10; i++) chk("r37_mem", shadow[i], prog[i]);

        start();
        for (int i = 0; i < 4; i++) send(prog[i], 1'b0);
        repeat (3) begin
            set(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 2'd0);
            cyc();
            chk("r38_gap_we", c_we, 0);
        end
        for (int i = 4; i < 10; i++) send(prog[i], i == 9);
        chk("r38_nwrites", waddr.size(), 10);
        for (int i = 0; i < waddr.size(); i++) chk("r38_addr", waddr[i], i);
        for (int i = 0; i < 10; i++) chk("r38_mem", shadow[i], prog[i]);
        chk("r38_run", cpu_run, 1);

        set(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd1);
        cyc();
        chk("r39_state", state, 3);
        chk("r39_fstat", final_status, 1);
        chk("r39_run", cpu_run, 0);
        repeat (3) begin
            set(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
            cyc();
        end
        chk("r39_hold_state", state, 3);
        chk("r39_hold_fstat", final_status, 1);

        start();
        for (int i = 0; i < 17; i++) send(8'(i + 1), 1'b0);
        chk("r40_nwrites", waddr.size(), 16);
        chk("r40_err", load_err, 1);
        chk("r40_fstat", final_status, 3);
        chk("r40_state", state, 3);
        chk("r40_count", byte_count, 16);
        for (int i = 0; i < MEM; i++) chk("r40_mem", shadow[i], 8'(i + 1));

        start();
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i), i == 15);
        chk("r41_state", state, 2);
        chk("r41_err", load_err, 0);
        chk("r41_count", byte_count, 16);
        chk("r41_run", cpu_run, 1);

        start();
        for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 1'b0);
        set(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 2'd0);
        cyc();
        chk("r42_rst_we", c_we, 0);
        chk("r42_state", state, 0);
        chk("r42_count", byte_count, 0);
        repeat (2) begin
            set(1'b1, 1'b0, 1'b1, 8'h66, 1'b1, 2'd0);
            cyc();
        end
        chk("r42_norun", cpu_run, 0);
        set(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
        cyc();
        waddr.delete();
        send(8'hA5, 1'b1);
        chk("r42_addr0", waddr.size() == 1 && waddr[0] == 0, 1);
        chk("r42_state_run", state, 2);

        for (int i = 0; i < 600; i++) begin
            set(1'($urandom_range(39) != 0), 1'($urandom_range(9) == 0), 1'($urandom_range(1)),
                8'($urandom), 1'($urandom_range(11) == 0),
                ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'd0);
            cyc();
            if (m_st == 2 && img.size() > 0)
                for (int k = 0; k < img.size(); k++) chk("rand_mem", shadow[k], mm[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
